// File: rtl/ingress_rr_mux.sv
// Ingress arbiter for the shared-SRAM switch: round-robin grant among ports, one packet
// at a time, serialised onto a registered stream with SRAM word addresses and header fields.
module ingress_rr_mux #(
    parameter int num_of_ports      = 16,
    parameter int sg_data_width     = 64,
    parameter int sg_address_width  = 12,
    parameter int sg_des_width      = 4,
    parameter int sg_priority_width = 3
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [num_of_ports-1:0]                 wr_sop,
    input  logic [num_of_ports-1:0]                 wr_eop,
    input  logic [num_of_ports-1:0]                 wr_vld,
    input  logic [num_of_ports*sg_data_width-1:0]   wr_data,
    output logic [num_of_ports-1:0]                 wr_ready,
    output logic                                    transfering,
    output logic [num_of_ports-1:0]                 eop,
    output logic                                    busy,
    output logic [sg_data_width-1:0]                data_out,
    output logic                                    out_valid,
    output logic [sg_address_width-1:0]             address_out,
    output logic [sg_des_width-1:0]                 des_port,
    output logic [sg_priority_width-1:0]            wr_priority
);

    localparam int PW = (num_of_ports > 1) ? $clog2(num_of_ports) : 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t                         state_reg, state_next;
    logic [PW-1:0]                  gnt_reg, gnt_next;
    logic [PW-1:0]                  rr_ptr_reg, rr_ptr_next;
    logic [sg_address_width-1:0]    base_reg, base_next;
    logic [sg_address_width-1:0]    pay_cnt_reg, pay_cnt_next;
    logic                           hdr_pend_reg, hdr_pend_next;

    logic                           transfering_reg, transfering_next;
    logic [num_of_ports-1:0]        eop_reg, eop_next;
    logic [sg_data_width-1:0]       data_out_reg, data_out_next;
    logic                           out_valid_reg, out_valid_next;
    logic [sg_address_width-1:0]    address_out_reg, address_out_next;
    logic [sg_des_width-1:0]        des_port_reg, des_port_next;
    logic [sg_priority_width-1:0]   wr_priority_reg, wr_priority_next;

    logic [sg_data_width-1:0]       port_data [num_of_ports];
    logic [sg_data_width-1:0]       sel_data;
    logic [num_of_ports-1:0]        request;
    logic                           arb_found;
    logic [PW-1:0]                  arb_idx;
    logic [PW-1:0]                  cand;
    logic                           accept;
    logic                           last_word;

    generate
        for (genvar gi = 0; gi < num_of_ports; gi++) begin : g_port
            assign port_data[gi] = wr_data[gi*sg_data_width +: sg_data_width];
            assign wr_ready[gi]  = (state_reg == XFER) && (gnt_reg == PW'(gi));
        end
    endgenerate

    assign sel_data  = port_data[gnt_reg];
    assign accept    = (state_reg == XFER) && wr_vld[gnt_reg];
    assign last_word = accept && wr_eop[gnt_reg];

    // Search starts one past the last grant; offset num_of_ports wraps back to rr_ptr itself.
    always_comb begin
        request   = wr_vld & wr_sop;
        arb_found = 1'b0;
        arb_idx   = rr_ptr_reg;
        cand      = rr_ptr_reg;
        for (int i = 1; i <= num_of_ports; i++) begin
            cand = rr_ptr_reg + PW'(i);
            if (!arb_found && request[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        gnt_next         = gnt_reg;
        rr_ptr_next      = rr_ptr_reg;
        base_next        = base_reg;
        pay_cnt_next     = pay_cnt_reg;
        hdr_pend_next    = hdr_pend_reg;
        transfering_next = 1'b0;
        eop_next         = '0;
        data_out_next    = '0;
        out_valid_next   = 1'b0;
        address_out_next = address_out_reg;
        des_port_next    = des_port_reg;
        wr_priority_next = wr_priority_reg;

        case (state_reg)
            IDLE: begin
                if (arb_found) begin
                    gnt_next      = arb_idx;
                    rr_ptr_next   = arb_idx;
                    state_next    = XFER;
                    hdr_pend_next = 1'b1;
                    pay_cnt_next  = '0;
                end
            end
            XFER: begin
                // Once the header is out, the stream stays active across source gaps.
                transfering_next = !hdr_pend_reg;
                if (accept) begin
                    transfering_next = 1'b1;
                    out_valid_next   = 1'b1;
                    data_out_next    = sel_data;
                    if (hdr_pend_reg) begin
                        hdr_pend_next    = 1'b0;
                        des_port_next    = sel_data[sg_des_width-1:0];
                        wr_priority_next = sel_data[sg_des_width +: sg_priority_width];
                        address_out_next = base_reg;
                    end else begin
                        address_out_next = base_reg + pay_cnt_reg;
                        pay_cnt_next     = pay_cnt_reg + 1'b1;
                    end
                    if (last_word) begin
                        eop_next[gnt_reg] = 1'b1;
                        state_next        = IDLE;
                        base_next         = base_reg + pay_cnt_next;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            gnt_reg         <= '0;
            rr_ptr_reg      <= PW'(num_of_ports - 1);
            base_reg        <= '0;
            pay_cnt_reg     <= '0;
            hdr_pend_reg    <= 1'b0;
            transfering_reg <= 1'b0;
            eop_reg         <= '0;
            data_out_reg    <= '0;
            out_valid_reg   <= 1'b0;
            address_out_reg <= '0;
            des_port_reg    <= '0;
            wr_priority_reg <= '0;
        end else begin
            state_reg       <= state_next;
            gnt_reg         <= gnt_next;
            rr_ptr_reg      <= rr_ptr_next;
            base_reg        <= base_next;
            pay_cnt_reg     <= pay_cnt_next;
            hdr_pend_reg    <= hdr_pend_next;
            transfering_reg <= transfering_next;
            eop_reg         <= eop_next;
            data_out_reg    <= data_out_next;
            out_valid_reg   <= out_valid_next;
            address_out_reg <= address_out_next;
            des_port_reg    <= des_port_next;
            wr_priority_reg <= wr_priority_next;
        end
    end

    assign busy        = (state_reg == XFER);
    assign transfering = transfering_reg;
    assign eop         = eop_reg;
    assign data_out    = data_out_reg;
    assign out_valid   = out_valid_reg;
    assign address_out = address_out_reg;
    assign des_port    = des_port_reg;
    assign wr_priority = wr_priority_reg;

endmodule

// File: tb/tb_ingress_rr_mux.sv
// Directed bench for ingress_rr_mux: per-port source queues drive packets, a scoreboard
// holds the expected stream word for each accept and is checked one cycle later.
module tb_ingress_rr_mux;

    localparam int N   = 16;
    localparam int W   = 64;
    localparam int AW  = 12;
    localparam int DW  = 4;
    localparam int PRW = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       wr_sop, wr_eop, wr_vld, wr_ready, eop;
    logic [N*W-1:0]     wr_data;
    logic               transfering, busy, out_valid;
    logic [W-1:0]       data_out;
    logic [AW-1:0]      address_out;
    logic [DW-1:0]      des_port;
    logic [PRW-1:0]     wr_priority;

    always #5 clk = ~clk;

    ingress_rr_mux #(
        .num_of_ports(N), .sg_data_width(W), .sg_address_width(AW),
        .sg_des_width(DW), .sg_priority_width(PRW)
    ) dut (
        .clk(clk), .rst(rst), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld),
        .wr_data(wr_data), .wr_ready(wr_ready), .transfering(transfering), .eop(eop),
        .busy(busy), .data_out(data_out), .out_valid(out_valid), .address_out(address_out),
        .des_port(des_port), .wr_priority(wr_priority)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         sop;
        logic         eop;
        int           gap;
    } word_t;

    typedef struct {
        logic [W-1:0]   d;
        logic [AW-1:0]  a;
        logic [N-1:0]   e;
        logic [DW-1:0]  des;
        logic [PRW-1:0] pr;
    } exp_t;

    word_t          src_q [N][$];
    exp_t           sb [$];
    logic [AW-1:0]  obs_addr [$];
    logic [N-1:0]   obs_eop [$];
    logic [W-1:0]   obs_data [$];

    int             n_checks = 0;
    int             n_pass   = 0;
    int             gap_cycles;

    logic [AW-1:0]  m_base, m_cnt, m_last_addr;
    logic           m_first;
    logic [DW-1:0]  m_des;
    logic [PRW-1:0] m_pr;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic add_pkt(input int p, input logic [W-1:0] hdr, input int npay,
                           input int gap_idx, input int gap_len);
        word_t w;
        w.d = hdr; w.sop = 1'b1; w.eop = (npay == 0); w.gap = 0;
        src_q[p].push_back(w);
        for (int k = 0; k < npay; k++) begin
            w.d   = {8'(p), 24'h0, 16'hBEEF, 16'(k)};
            w.sop = 1'b0;
            w.eop = (k == npay - 1);
            w.gap = (k == gap_idx) ? gap_len : 0;
            src_q[p].push_back(w);
        end
    endtask

    task automatic drive();
        word_t w;
        wr_vld = '0; wr_sop = '0; wr_eop = '0; wr_data = '0;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                w = src_q[i][0];
                if (w.gap > 0) begin
                    w.gap--;
                    src_q[i][0] = w;
                end else begin
                    wr_vld[i]          = 1'b1;
                    wr_sop[i]          = w.sop;
                    wr_eop[i]          = w.eop;
                    wr_data[i*W +: W]  = w.d;
                end
            end
        end
    endtask

    task automatic check_out();
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("out_valid", out_valid, 1);
            chk("data_out", data_out, x.d);
            chk("address_out", address_out, x.a);
            chk("eop", eop, x.e);
            chk("des_port", des_port, x.des);
            chk("wr_priority", wr_priority, x.pr);
            chk("transfering", transfering, 1);
            m_last_addr = x.a;
            obs_addr.push_back(address_out);
            obs_eop.push_back(eop);
            obs_data.push_back(data_out);
        end else begin
            chk("idle_out_valid", out_valid, 0);
            chk("idle_data_out", data_out, 0);
            chk("idle_eop", eop, 0);
            chk("idle_transfering", transfering, !m_first);
            if (!m_first) begin
                chk("gap_addr_hold", address_out, m_last_addr);
                gap_cycles++;
            end
        end
    endtask

    task automatic tick();
        int    acc;
        word_t w;
        exp_t  x;
        drive();
        #1;
        chk("one_ready", ($countones(wr_ready) <= 1), 1);
        acc = -1;
        for (int i = 0; i < N; i++)
            if (wr_vld[i] && wr_ready[i]) acc = i;
        if (acc >= 0) begin
            w   = src_q[acc].pop_front();
            x.d = w.d;
            x.e = '0;
            if (w.eop) x.e[acc] = 1'b1;
            if (m_first) begin
                m_des   = w.d[3:0];
                m_pr    = w.d[6:4];
                x.a     = m_base;
                m_first = 1'b0;
                m_cnt   = '0;
            end else begin
                x.a   = m_base + m_cnt;
                m_cnt = m_cnt + 1'b1;
            end
            x.des = m_des;
            x.pr  = m_pr;
            sb.push_back(x);
            if (w.eop) begin
                m_base  = m_base + m_cnt;
                m_first = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_out();
    endtask

    function automatic bit pending();
        bit p = (sb.size() > 0);
        for (int i = 0; i < N; i++)
            if (src_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic run(input int max_cycles);
        int c = 0;
        while (pending() && c < max_cycles) begin
            tick();
            c++;
        end
        chk("timeout", pending(), 0);
        tick();
        tick();
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_eop.delete();
        obs_data.delete();
        gap_cycles = 0;
    endtask

    task automatic do_reset();
        drive();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_transfering", transfering, 0);
        chk("rst_eop", eop, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_address_out", address_out, 0);
        chk("rst_des_port", des_port, 0);
        chk("rst_wr_priority", wr_priority, 0);
        rst         = 1'b0;
        m_base      = '0;
        m_cnt       = '0;
        m_last_addr = '0;
        m_first     = 1'b1;
        m_des       = '0;
        m_pr        = '0;
        sb.delete();
        for (int i = 0; i < N; i++) src_q[i].delete();
        clear_obs();
    endtask

    initial begin
        rst = 1'b1;
        wr_vld = '0; wr_sop = '0; wr_eop = '0; wr_data = '0;
        do_reset();

        // Port 3, header 0x25, four payload words from base 0.
        add_pkt(3, 64'h25, 4, -1, 0);
        run(50);
        chk("p3_count", obs_addr.size(), 5);
        chk("p3_hdr_data", obs_data[0], 64'h25);
        chk("p3_hdr_addr", obs_addr[0], 0);
        for (int k = 0; k < 4; k++) chk("p3_pay_addr", obs_addr[k+1], 12'(k));
        chk("p3_eop", obs_eop[4], 16'h0008);
        chk("p3_eop_early", obs_eop[3], 16'h0000);
        chk("p3_des", des_port, 5);
        chk("p3_prio", wr_priority, 2);

        // Ports 0, 1, 2 request together after rr_ptr settled on 3.
        clear_obs();
        add_pkt(0, 64'h10, 1, -1, 0);
        add_pkt(1, 64'h21, 1, -1, 0);
        add_pkt(2, 64'h32, 1, -1, 0);
        run(50);
        chk("rr_base_after_p3", obs_addr[0], 4);
        chk("rr_first", obs_eop[1], 16'h0001);
        chk("rr_second", obs_eop[3], 16'h0002);
        chk("rr_third", obs_eop[5], 16'h0004);

        // Next round: port 3 precedes port 1.
        clear_obs();
        add_pkt(1, 64'h41, 1, -1, 0);
        add_pkt(3, 64'h43, 1, -1, 0);
        run(50);
        chk("rr_next_first", obs_eop[1], 16'h0008);
        chk("rr_next_second", obs_eop[3], 16'h0002);
        chk("rr_next_addr", obs_addr[0], 7);

        // Header-only packet on port 9.
        clear_obs();
        add_pkt(9, 64'h59, 0, -1, 0);
        run(50);
        chk("ho_count", obs_addr.size(), 1);
        chk("ho_eop", obs_eop[0], 16'h0200);
        chk("ho_addr", obs_addr[0], 9);

        // Two-cycle source gap before payload word 2.
        clear_obs();
        add_pkt(4, 64'h64, 5, 2, 2);
        run(60);
        chk("gap_cycles", gap_cycles, 2);
        chk("gap_hdr_addr", obs_addr[0], 9);
        for (int k = 0; k < 5; k++) chk("gap_pay_addr", obs_addr[k+1], 12'(9 + k));

        // Fill base up to 0xFFE, then wrap.
        clear_obs();
        add_pkt(5, 64'h75, 4080, -1, 0);
        run(5000);
        clear_obs();
        add_pkt(7, 64'h87, 4, -1, 0);
        run(50);
        chk("wrap_hdr", obs_addr[0], 12'hFFE);
        chk("wrap_a0", obs_addr[1], 12'hFFE);
        chk("wrap_a1", obs_addr[2], 12'hFFF);
        chk("wrap_a2", obs_addr[3], 12'h000);
        chk("wrap_a3", obs_addr[4], 12'h001);
        clear_obs();
        add_pkt(8, 64'h98, 0, -1, 0);
        run(50);
        chk("wrap_base", obs_addr[0], 12'h002);

        // Reset during payload word 2 of a port 14 packet.
        clear_obs();
        add_pkt(14, 64'hE3, 5, -1, 0);
        for (int c = 0; c < 4; c++) tick();
        do_reset();
        add_pkt(14, 64'hE3, 2, -1, 0);
        add_pkt(15, 64'hF1, 0, -1, 0);
        add_pkt(0, 64'h02, 1, -1, 0);
        run(60);
        chk("rst_resend_base", obs_addr[0], 0);
        chk("rst_port0_first", obs_eop[1], 16'h0001);
        chk("rst_port14", obs_eop[4], 16'h4000);
        chk("rst_port15", obs_eop[5], 16'h8000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
